// File: rtl/polaris_prefetch_queue.sv
// Instruction prefetch queue: keeps a DEPTH-entry FIFO of {pc, instruction} pairs
// filled from a sequential fetch pointer, with flushing redirect and misaligned-target flag.
module polaris_prefetch_queue #(
  parameter int unsigned AW           = 64,
  parameter int unsigned DEPTH        = 4,
  parameter logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic [AW-1:0]              iadr_o,
  output logic [1:0]                 isiz_o,
  output logic                       istb_o,
  input  logic                       iack_i,
  input  logic [31:0]                idat_i,
  input  logic                       redirect_i,
  input  logic [AW-1:0]              redirect_adr_i,
  input  logic                       take_i,
  output logic                       valid_o,
  output logic [31:0]                inst_o,
  output logic [AW-1:0]              pc_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       afault_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic [AW-1:0] fptr_q, fptr_n;
  logic [PW-1:0] rd_q, rd_n, wr_q, wr_n;
  logic [CW-1:0] cnt_n;
  logic          afault_n;
  logic          push_c, pop_c;

  logic          istb_n, valid_n;
  logic [AW-1:0] iadr_n, pc_n;
  logic [1:0]    isiz_n;
  logic [31:0]   inst_n;

  // Next state, plus next values of the registered outputs.
  always_comb begin
    push_c   = istb_o & iack_i & ~redirect_i;
    pop_c    = take_i & valid_o & ~redirect_i;
    fptr_n   = fptr_q;
    rd_n     = rd_q;
    wr_n     = wr_q;
    cnt_n    = count_o;
    afault_n = afault_o;

    if (redirect_i) begin
      fptr_n   = redirect_adr_i;
      rd_n     = '0;
      wr_n     = '0;
      cnt_n    = '0;
      afault_n = |redirect_adr_i[1:0];
    end else begin
      if (push_c) begin
        fptr_n = fptr_q + AW'(4);
        wr_n   = wr_q + PW'(1);
      end
      if (pop_c) begin
        rd_n = rd_q + PW'(1);
      end
      if (push_c && !pop_c) begin
        cnt_n = count_o + CW'(1);
      end else if (pop_c && !push_c) begin
        cnt_n = count_o - CW'(1);
      end
    end

    istb_n  = (cnt_n < CW'(DEPTH)) & ~afault_n;
    iadr_n  = istb_n ? fptr_n : '0;
    isiz_n  = istb_n ? 2'b10 : 2'b00;
    valid_n = (cnt_n != '0);
    pc_n    = '0;
    inst_n  = '0;
    // The word being written this edge becomes the head when the queue drains to it.
    if (valid_n) begin
      if (push_c && (wr_q == rd_n)) begin
        pc_n   = fptr_q;
        inst_n = idat_i;
      end else begin
        pc_n   = pc_mem[rd_n];
        inst_n = inst_mem[rd_n];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fptr_q   <= AW'(RESET_VECTOR);
      rd_q     <= '0;
      wr_q     <= '0;
      count_o  <= '0;
      afault_o <= 1'b0;
      istb_o   <= 1'b0;
      iadr_o   <= '0;
      isiz_o   <= 2'b00;
      valid_o  <= 1'b0;
      pc_o     <= '0;
      inst_o   <= '0;
    end else begin
      fptr_q   <= fptr_n;
      rd_q     <= rd_n;
      wr_q     <= wr_n;
      count_o  <= cnt_n;
      afault_o <= afault_n;
      istb_o   <= istb_n;
      iadr_o   <= iadr_n;
      isiz_o   <= isiz_n;
      valid_o  <= valid_n;
      pc_o     <= pc_n;
      inst_o   <= inst_n;
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      pc_mem[wr_q]   <= fptr_q;
      inst_mem[wr_q] <= idat_i;
    end
  end

endmodule
